// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_if
// Description : Load/shift handshake bundle for the PISO serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_enable;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_last;
    logic [CNT_W-1:0] word_count;

    // Producer and consumer side, seen from outside the serializer
    modport master (
        output parallel_in, load_valid, shift_enable,
        input  load_ready, serial_out, serial_valid, frame_start, frame_last, word_count
    );

    modport slave (
        input  parallel_in, load_valid, shift_enable,
        output load_ready, serial_out, serial_valid, frame_start, frame_last, word_count
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in/serial-out stage with one-word holding buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  wire logic            clock,
    input  wire logic            reset,
    piso_serializer_if.slave     bus
);
    localparam int                 c_BIT_W   = $clog2(WIDTH);
    localparam logic [c_BIT_W-1:0] c_LAST    = c_BIT_W'(WIDTH - 1);
    localparam int                 c_OUT_BIT = MSB_FIRST ? WIDTH - 1 : 0;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0]   r_word_count;

    logic w_load;
    logic w_consume;
    logic w_end_word;

    assign w_load     = bus.load_valid & ~r_hold_full;
    assign w_consume  = (r_state == c_SHIFT) & bus.shift_enable;
    assign w_end_word = w_consume & (r_bit_cnt == c_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_load) begin
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (w_end_word && !r_hold_full && !w_load) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: shift register, holding buffer, counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sreg       <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_bit_cnt    <= '0;
            r_word_count <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_load) begin
                r_sreg    <= bus.parallel_in;
                r_bit_cnt <= '0;
            end
        end else begin
            if (w_end_word) begin
                r_word_count <= r_word_count + CNT_W'(1);
                if (r_hold_full) begin
                    r_sreg      <= r_hold;
                    r_hold_full <= 1'b0;
                    r_bit_cnt   <= '0;
                end else if (w_load) begin
                    r_sreg    <= bus.parallel_in;
                    r_bit_cnt <= '0;
                end
            end else begin
                if (w_consume) begin
                    r_sreg    <= MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
                // Any load that cannot go straight into sreg parks in hold
                if (w_load) begin
                    r_hold      <= bus.parallel_in;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

    // Output decode, purely from registered state
    always_comb begin
        bus.serial_valid = (r_state == c_SHIFT);
        bus.serial_out   = bus.serial_valid & r_sreg[c_OUT_BIT];
        bus.frame_start  = bus.serial_valid & (r_bit_cnt == '0);
        bus.frame_last   = bus.serial_valid & (r_bit_cnt == c_LAST);
        bus.load_ready   = ~r_hold_full;
        bus.word_count   = r_word_count;
    end
endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage sitting directly downstream of the 4-bit parallel register: it accepts a `WIDTH`-bit word over a valid/ready handshake and shifts it out one bit per accepted cycle under consumer back-pressure. A one-entry holding buffer lets the next word load while the current word shifts, so back-to-back words stream with no idle cycle. A wrapping frame counter reports completed words.

## Interface
- `WIDTH`, 4: word width in bits; must be at least 2.
- `MSB_FIRST`, 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `CNT_W`, 8: width of `word_count`.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `parallel_in`  in  WIDTH  word to serialize; sampled on handshake.
- `load_valid`  in  1  producer has a word on `parallel_in`.
- `load_ready`  out  1  block can accept a word this cycle.
- `shift_enable`  in  1  consumer takes the current bit this cycle.
- `serial_out`  out  1  current bit; 0 when `serial_valid`=0.
- `serial_valid`  out  1  `serial_out` carries a valid bit.
- `frame_start`  out  1  current bit is the first of a word.
- `frame_last`  out  1  current bit is the last of a word.
- `word_count`  out  CNT_W  number of fully consumed words, modulo 2^CNT_W.

## Operation
- State: shift register `sreg`, bit counter `bit_cnt` (0..WIDTH-1), holding register `hold` with flag `hold_full`, FSM {IDLE, SHIFT}, and `word_count`.
- Load handshake: a load occurs at an edge where `load_valid`=1 and `load_ready`=1. `load_ready` = !`hold_full`.
- IDLE: a load writes `parallel_in` into `sreg`, sets `bit_cnt`=0, and moves the FSM to SHIFT.
- SHIFT: `serial_valid`=1. A bit is consumed at an edge where `shift_enable`=1. If `shift_enable`=0, `sreg`, `bit_cnt` and all outputs hold.
- Consumed bit with `bit_cnt`<WIDTH-1:
  - `sreg` shifts toward the output end (left if `MSB_FIRST`, else right).
  - `bit_cnt` increments.
- Consumed bit with `bit_cnt`=WIDTH-1 (end of word): `word_count` increments, wrapping from 2^CNT_W-1 to 0. Then the first matching case applies:
  - `hold_full`: `hold` moves to `sreg`, `hold_full` clears, `bit_cnt`=0, FSM stays in SHIFT.
  - Otherwise, a load at the same edge: `parallel_in` goes directly to `sreg`, `bit_cnt`=0, FSM stays in SHIFT.
  - Otherwise: FSM goes to IDLE.
- A load in SHIFT that does not go directly to `sreg` writes `hold` and sets `hold_full`.
- A load and a hold-to-`sreg` transfer at the same edge cannot occur, because `load_ready`=0 whenever `hold_full`=1.
- Output decode:
  - `serial_out` = `sreg[WIDTH-1]` if `MSB_FIRST`, else `sreg[0]`; forced to 0 when `serial_valid`=0.
  - `frame_start` = `serial_valid` & (`bit_cnt`==0).
  - `frame_last` = `serial_valid` & (`bit_cnt`==WIDTH-1).
- Reset (asserted at any time, including mid-word): FSM=IDLE; `sreg`, `hold`, `bit_cnt`, `word_count` = 0; `hold_full`=0. A partially shifted word and any held word are discarded and not counted.
- Inputs are ignored while `reset`=1.

## Timing
- Reset values: `load_ready`=1, `serial_out`=0, `serial_valid`=0, `frame_start`=0, `frame_last`=0, `word_count`=0.
- Outputs are decoded only from registered state; there is no combinational path from any input to any output.
- Load latency: a load at edge N in IDLE gives `serial_valid`=1 and `frame_start`=1 in the cycle after edge N.
- With `shift_enable` held at 1, a word occupies exactly WIDTH cycles and its last bit is consumed at edge N+WIDTH.
- Back-to-back loads: the next word's first bit is valid in the cycle immediately after the previous word's last-bit edge. Sustained throughput is 1 bit per cycle with no gap.
- `word_count` updates on the edge that consumes the last bit and is visible in the following cycle.

## Test plan
- Reset: assert `reset` mid-cycle with no clock edge -> all outputs take their reset values immediately, and `load_ready`=1.
- Single word, `MSB_FIRST`=1, `parallel_in`=1010, `shift_enable`=1 -> `serial_out` = 1,0,1,0 in cycles 1-4 after the load; `frame_start` in cycle 1; `frame_last` in cycle 4; `serial_valid`=0 in cycle 5; `word_count`=1.
- Streaming 1010, 1100, 0011 with `load_valid` held -> 12 contiguous valid bits 101011000011; `frame_start` every 4th bit; `load_ready` drops to 0 while `hold` is full; `word_count`=3.
- Stall: `shift_enable`=0 for 3 cycles at `bit_cnt`=1 of 1100 -> `serial_out`=1 and `bit_cnt` hold; shifting resumes correctly when `shift_enable` returns to 1.
- `MSB_FIRST`=0, `parallel_in`=0011 -> `serial_out` = 1,1,0,0.
- Reset mid-word after 2 bits, with `hold` full -> FSM returns to IDLE, `word_count`=0, and no further valid bits appear.
- Counter wrap with `CNT_W`=2: five words -> `word_count` = 1, 2, 3, 0, 1.
